// File: rtl/ctrl_pipe_n.sv
// ctrl_pipe_n: generic N-stage control-bundle pipeline for the MIPS core.
//
// Stage 1 follows decode (E by default), stage 2 is M, stage 3 is W.
// Every stage has a valid bit and a CTRL_W-bit bundle. A bundle is forced
// to zero whenever its valid bit is zero, so downstream logic can use
// regwrite/memwrite without gating them.
//
// Per stage, in priority order: flush clears, a branch redirect squashes
// stages younger than BR_STAGE, stall holds, a stalled upstream stage
// inserts a bubble, otherwise the upstream content is loaded.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   ctrl_d       control bundle from decode
//   valid_d      decode holds a real instruction
//   stall        bit k-1 holds stage k
//   flush        bit k-1 clears stage k
//   branch_ok    branch condition for the instruction in BR_STAGE
//   ctrl_q       stage k bundle at [k*CTRL_W-1 : (k-1)*CTRL_W]
//   valid_q      per-stage valid
//   pcsrc        take branch (combinational from the BR_STAGE register)
//   flush_front  flush fetch/decode, same as pcsrc
//   stall_err    one-cycle pulse after a non-monotonic stall pattern
//   bubble_cnt   wrap-around count of inserted bubbles
module ctrl_pipe_n #(
    parameter int CTRL_W   = 16,
    parameter int NSTAGE   = 3,
    parameter int BR_STAGE = 2,
    parameter int BR_BIT   = 8,
    parameter int BUB_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CTRL_W-1:0]        ctrl_d,
    input  logic                     valid_d,
    input  logic [NSTAGE-1:0]        stall,
    input  logic [NSTAGE-1:0]        flush,
    input  logic                     branch_ok,
    output logic [NSTAGE*CTRL_W-1:0] ctrl_q,
    output logic [NSTAGE-1:0]        valid_q,
    output logic                     pcsrc,
    output logic                     flush_front,
    output logic                     stall_err,
    output logic [BUB_W-1:0]         bubble_cnt
);

    localparam int BR_IDX = BR_STAGE - 1;

    logic [NSTAGE*CTRL_W-1:0] ctrl_reg;
    logic [NSTAGE*CTRL_W-1:0] ctrl_next;
    logic [NSTAGE-1:0]        valid_reg;
    logic [NSTAGE-1:0]        valid_next;
    logic [NSTAGE-1:0]        bub_next;
    logic [BUB_W-1:0]         bubble_cnt_reg;
    logic [BUB_W-1:0]         bub_sum;
    logic                     stall_err_reg;
    logic                     stall_illegal;
    logic                     redirect;

    // Redirect is decided from the registered branch stage, so the front end
    // sees it in the same cycle the branch sits there.
    assign redirect = valid_reg[BR_IDX]
                    & ctrl_reg[BR_IDX*CTRL_W + BR_BIT]
                    & branch_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
            // Stages strictly younger than the branch stage are wrong-path on redirect.
            localparam bit SQUASH = (gi + 1) < BR_STAGE;

            logic [CTRL_W-1:0] up_ctrl;
            logic              up_valid;
            logic              up_bub;
            logic              up_stall;
            logic [CTRL_W-1:0] c_nxt;
            logic              v_nxt;
            logic              b_nxt;

            if (gi == 0) begin : g_first
                // Decode is wrong-path under redirect: load a (counted) bubble.
                assign up_ctrl  = (valid_d && !redirect) ? ctrl_d : '0;
                assign up_valid = valid_d & ~redirect;
                assign up_bub   = redirect;
                assign up_stall = 1'b0;
            end else begin : g_rest
                assign up_ctrl  = ctrl_reg[(gi-1)*CTRL_W +: CTRL_W];
                assign up_valid = valid_reg[gi-1];
                assign up_bub   = 1'b0;
                assign up_stall = stall[gi-1];
            end

            always_comb begin
                c_nxt = up_ctrl;
                v_nxt = up_valid;
                b_nxt = up_bub;
                if (flush[gi]) begin
                    c_nxt = '0;
                    v_nxt = 1'b0;
                    b_nxt = 1'b0;
                end else if (SQUASH && redirect) begin
                    c_nxt = '0;
                    v_nxt = 1'b0;
                    b_nxt = 1'b0;
                end else if (stall[gi]) begin
                    c_nxt = ctrl_reg[gi*CTRL_W +: CTRL_W];
                    v_nxt = valid_reg[gi];
                    b_nxt = 1'b0;
                end else if (up_stall) begin
                    // Upstream is held, so nothing moves into this stage.
                    c_nxt = '0;
                    v_nxt = 1'b0;
                    b_nxt = 1'b1;
                end
            end

            assign ctrl_next[gi*CTRL_W +: CTRL_W] = c_nxt;
            assign valid_next[gi]                 = v_nxt;
            assign bub_next[gi]                   = b_nxt;
        end
    endgenerate

    // Number of bubble insertions on this edge (0..NSTAGE).
    always_comb begin
        bub_sum = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            bub_sum = bub_sum + {{(BUB_W-1){1'b0}}, bub_next[i]};
        end
    end

    // A stage stalled while the stage feeding it is not: the hazard unit broke
    // the monotonic-stall contract.
    assign stall_illegal = |(stall[NSTAGE-1:1] & ~stall[NSTAGE-2:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_reg       <= '0;
            valid_reg      <= '0;
            bubble_cnt_reg <= '0;
            stall_err_reg  <= 1'b0;
        end else begin
            ctrl_reg       <= ctrl_next;
            valid_reg      <= valid_next;
            bubble_cnt_reg <= bubble_cnt_reg + bub_sum;
            stall_err_reg  <= stall_illegal;
        end
    end

    assign ctrl_q      = ctrl_reg;
    assign valid_q     = valid_reg;
    assign pcsrc       = redirect;
    assign flush_front = redirect;
    assign stall_err   = stall_err_reg;
    assign bubble_cnt  = bubble_cnt_reg;

endmodule

// File: tb/tb_ctrl_pipe_n.sv
// tb_ctrl_pipe_n: scoreboard bench for ctrl_pipe_n (3 stages, branch at
// stage 2, 4-bit bubble counter so wrap-around is reachable).
// The driver issues one transaction per cycle and pushes the expected
// response; a monitor pops it and compares pcsrc before the edge and the
// registered outputs after it.
module tb_ctrl_pipe_n;

    localparam int CW = 16;
    localparam int N  = 3;
    localparam int BR = 2;
    localparam int BB = 8;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CW-1:0]   ctrl_d = '0;
    logic            valid_d = 1'b0;
    logic [N-1:0]    stall = '0;
    logic [N-1:0]    flush = '0;
    logic            branch_ok = 1'b0;
    logic [N*CW-1:0] ctrl_q;
    logic [N-1:0]    valid_q;
    logic            pcsrc;
    logic            flush_front;
    logic            stall_err;
    logic [BW-1:0]   bubble_cnt;

    ctrl_pipe_n #(.CTRL_W(CW), .NSTAGE(N), .BR_STAGE(BR), .BR_BIT(BB), .BUB_W(BW)) dut (
        .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d),
        .stall(stall), .flush(flush), .branch_ok(branch_ok),
        .ctrl_q(ctrl_q), .valid_q(valid_q), .pcsrc(pcsrc),
        .flush_front(flush_front), .stall_err(stall_err), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference state: one record per stage (index 0 = stage 1).
    logic [CW-1:0] m_ctrl [N];
    logic          m_valid[N];
    int            m_bub = 0;

    typedef struct {
        logic          pc;
        logic [N*CW-1:0] cq;
        logic [N-1:0]  vq;
        logic [BW-1:0] bc;
        logic          se;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One cycle of stimulus; the reference applies the stage rules to whole
    // stage records and records the expected outcome.
    task automatic step(input logic [CW-1:0] cd, input logic vd, input logic [N-1:0] st,
                        input logic [N-1:0] fl, input logic bo, input logic rs);
        exp_t          e;
        logic [CW-1:0] nc[N];
        logic          nv[N];
        logic          redir;
        logic          illegal;
        int            nb;
        @(negedge clk);
        ctrl_d = cd; valid_d = vd; stall = st; flush = fl; branch_ok = bo; rst = rs;

        redir = m_valid[BR-1] && m_ctrl[BR-1][BB] && bo;
        e.pc  = redir;
        nb    = 0;
        illegal = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (fl[k-1]) begin
                nc[k-1] = '0; nv[k-1] = 1'b0;
            end else if (redir && k < BR) begin
                nc[k-1] = '0; nv[k-1] = 1'b0;
            end else if (st[k-1]) begin
                nc[k-1] = m_ctrl[k-1]; nv[k-1] = m_valid[k-1];
            end else if (k >= 2 && st[k-2]) begin
                nc[k-1] = '0; nv[k-1] = 1'b0; nb++;
            end else if (k == 1) begin
                if (redir) begin
                    nc[0] = '0; nv[0] = 1'b0; nb++;
                end else begin
                    nc[0] = vd ? cd : '0; nv[0] = vd;
                end
            end else begin
                nc[k-1] = m_ctrl[k-2]; nv[k-1] = m_valid[k-2];
            end
            if (k >= 2 && st[k-1] && !st[k-2]) illegal = 1'b1;
        end

        if (!rs) begin
            for (int k = 0; k < N; k++) begin
                m_ctrl[k] = '0; m_valid[k] = 1'b0;
            end
            m_bub = 0;
            e.se  = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                m_ctrl[k] = nc[k]; m_valid[k] = nv[k];
            end
            m_bub = (m_bub + nb) % (1 << BW);
            e.se  = illegal;
        end
        for (int k = 0; k < N; k++) begin
            e.cq[k*CW +: CW] = m_ctrl[k];
            e.vq[k]          = m_valid[k];
        end
        e.bc = BW'(m_bub);
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pcsrc is checked while the inputs of the cycle are applied,
    // the registered outputs just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pcsrc", 64'(pcsrc), 64'(e.pc));
                chk("flush_front", 64'(flush_front), 64'(e.pc));
                @(posedge clk);
                #1;
                chk("ctrl_q", 64'(ctrl_q), 64'(e.cq));
                chk("valid_q", 64'(valid_q), 64'(e.vq));
                chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bc));
                chk("stall_err", 64'(stall_err), 64'(e.se));
                txn++;
                $display("txn %0d pcsrc=%b valid=%b ctrl=%h bub=%0d err=%b",
                         txn, pcsrc, valid_q, ctrl_q, bubble_cnt, stall_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            m_ctrl[k] = '0; m_valid[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl_q", 64'(ctrl_q), 64'h0);
        chk("reset valid_q", 64'(valid_q), 64'h0);
        chk("reset bubble_cnt", 64'(bubble_cnt), 64'h0);
        chk("reset stall_err", 64'(stall_err), 64'h0);

        // Plain streaming latency.
        step(16'h0101, 1, 3'b000, 3'b000, 0, 1);
        settle();
        chk("t1 stage1", 64'(ctrl_q[15:0]), 64'h0101);
        step(16'h0202, 1, 3'b000, 3'b000, 0, 1);
        settle();
        chk("t1 stage2", 64'(ctrl_q[31:16]), 64'h0101);
        step(16'h0303, 1, 3'b000, 3'b000, 0, 1);
        settle();
        chk("t1 stage3", 64'(ctrl_q[47:32]), 64'h0101);
        chk("t1 bubbles", 64'(bubble_cnt), 64'h0);

        // Hold stages 1-2 for two cycles.
        step(16'h0404, 1, 3'b011, 3'b000, 0, 1);
        step(16'h0404, 1, 3'b011, 3'b000, 0, 1);
        settle();
        chk("t2 stage1 hold", 64'(ctrl_q[15:0]), 64'h0303);
        chk("t2 stage2 hold", 64'(ctrl_q[31:16]), 64'h0202);
        chk("t2 stage3 bubble", 64'({valid_q[2], ctrl_q[47:32]}), 64'h0);
        chk("t2 bubbles", 64'(bubble_cnt), 64'h2);
        step(16'h0404, 1, 3'b000, 3'b000, 0, 1);
        settle();
        chk("t2 resume", 64'(ctrl_q[47:32]), 64'h0202);

        // Taken branch at stage 2.
        step(16'h0155, 1, 3'b000, 3'b000, 0, 1);
        step(16'h0666, 1, 3'b000, 3'b000, 0, 1);
        step(16'h0222, 1, 3'b000, 3'b000, 1, 1);
        #1;
        chk("t3 pcsrc", 64'(pcsrc), 64'h1);
        settle();
        chk("t3 stage1 squashed", 64'({valid_q[0], ctrl_q[15:0]}), 64'h0);
        chk("t3 branch in stage3", 64'(ctrl_q[47:32]), 64'h0155);

        // Branch bundle with condition false.
        step(16'h0155, 1, 3'b000, 3'b000, 0, 1);
        step(16'h0444, 1, 3'b000, 3'b000, 0, 1);
        step(16'h0555, 1, 3'b000, 3'b000, 0, 1);
        #1;
        chk("t4 pcsrc", 64'(pcsrc), 64'h0);
        settle();
        chk("t4 advance", 64'(ctrl_q[47:32]), 64'h0155);

        // Flush beats stall.
        step(16'h0666, 1, 3'b011, 3'b010, 0, 1);
        settle();
        chk("t5 valid", 64'(valid_q), 64'h1);
        chk("t5 stage1 hold", 64'(ctrl_q[15:0]), 64'h0555);

        // Reset mid-stall, illegal stall pattern, counter wrap.
        step(16'h0777, 1, 3'b011, 3'b000, 0, 0);
        settle();
        chk("t6 reset ctrl", 64'(ctrl_q), 64'h0);
        chk("t6 reset bub", 64'(bubble_cnt), 64'h0);
        step(16'h0111, 1, 3'b010, 3'b000, 0, 1);
        settle();
        chk("t6 stall_err pulse", 64'(stall_err), 64'h1);
        step(16'h0000, 0, 3'b000, 3'b000, 0, 1);
        settle();
        chk("t6 stall_err clear", 64'(stall_err), 64'h0);
        step(16'h0000, 0, 3'b000, 3'b000, 0, 0);
        repeat (15) step(16'h0abc, 1, 3'b001, 3'b000, 0, 1);
        settle();
        chk("t6 bub 15", 64'(bubble_cnt), 64'hf);
        step(16'h0abc, 1, 3'b001, 3'b000, 0, 1);
        settle();
        chk("t6 bub wrap", 64'(bubble_cnt), 64'h0);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            logic [N-1:0]  st;
            logic [N-1:0]  fl;
            logic [CW-1:0] cd;
            int            r;
            r  = $urandom_range(0, 9);
            st = (r <= 5) ? 3'b000 : (r == 6) ? 3'b001 : (r == 7) ? 3'b011 :
                 (r == 8) ? 3'b111 : 3'($urandom);
            fl = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
            cd = 16'($urandom);
            cd[BB] = ($urandom_range(0, 2) == 0);
            step(cd, 1'($urandom), st, fl, 1'($urandom),
                 ($urandom_range(0, 49) != 0));
        end

        @(posedge clk);
        #5;
        chk("scoreboard drained", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
